// File: rtl/fifo_drain_stream.sv
// Drains syn_fifo into a valid/ready stream through a 2-entry main+skid buffer; 1-cycle pop-to-output latency.
// Pops stop when the buffer is full, so backpressure never loses a word; bursts of BURST beats carry m_last_o.
module fifo_drain_stream #(
  parameter int DWID  = 16,
  parameter int BURST = 4,
  parameter int CWID  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en_i,
  input  logic            fifo_empty_i,
  input  logic [DWID-1:0] fifo_rdata_i,
  output logic            fifo_rd_o,
  output logic            m_valid_o,
  input  logic            m_ready_i,
  output logic [DWID-1:0] m_data_o,
  output logic            m_last_o,
  output logic            busy_o,
  output logic [CWID-1:0] words_o
);

  localparam int PCW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [PCW-1:0] LAST_CNT = PCW'(BURST - 1);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t            state_q, state_d;
  logic [1:0]        occ_q, occ_d;
  logic [PCW-1:0]    pop_cnt_q, pop_cnt_d;
  logic [DWID-1:0]   main_dat_q, main_dat_d, skid_dat_q, skid_dat_d;
  logic              main_last_q, main_last_d, skid_last_q, skid_last_d;
  logic [CWID-1:0]   words_q, words_d;

  logic pop_ok, pop, accept, pop_last, to_main;

  // Pop permission comes only from registered state so fifo_rd_o never sees m_ready_i.
  assign pop_ok    = (state_q == FINISH) || ((state_q == RUN) && en_i);
  assign pop       = pop_ok && !fifo_empty_i && (occ_q != 2'd2);
  assign accept    = (occ_q != 2'd0) && m_ready_i;
  assign pop_last  = (pop_cnt_q == LAST_CNT);
  assign to_main   = (occ_q == 2'd0) || ((occ_q == 2'd1) && accept);

  assign fifo_rd_o = pop;
  assign m_valid_o = (occ_q != 2'd0);
  assign m_data_o  = main_dat_q;
  assign m_last_o  = main_last_q;
  assign busy_o    = (state_q != IDLE) || (occ_q != 2'd0);
  assign words_o   = words_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en_i) state_d = RUN;
      RUN:     if (!en_i) state_d = (pop_cnt_q == '0) ? IDLE : FINISH;
      FINISH:  if (pop && pop_last) state_d = en_i ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pop_cnt_d   = pop_cnt_q;
    occ_d       = occ_q + {1'b0, pop} - {1'b0, accept};
    main_dat_d  = main_dat_q;
    main_last_d = main_last_q;
    skid_dat_d  = skid_dat_q;
    skid_last_d = skid_last_q;
    words_d     = accept ? words_q + CWID'(1) : words_q;
    if (pop) pop_cnt_d = pop_last ? '0 : pop_cnt_q + PCW'(1);
    if (accept && (occ_q == 2'd2)) begin
      main_dat_d  = skid_dat_q;
      main_last_d = skid_last_q;
    end
    // A popped word lands in main only if main is free by the end of this cycle.
    if (pop) begin
      if (to_main) begin
        main_dat_d  = fifo_rdata_i;
        main_last_d = pop_last;
      end else begin
        skid_dat_d  = fifo_rdata_i;
        skid_last_d = pop_last;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      occ_q       <= 2'd0;
      pop_cnt_q   <= '0;
      main_dat_q  <= '0;
      main_last_q <= 1'b0;
      skid_dat_q  <= '0;
      skid_last_q <= 1'b0;
      words_q     <= '0;
    end else begin
      state_q     <= state_d;
      occ_q       <= occ_d;
      pop_cnt_q   <= pop_cnt_d;
      main_dat_q  <= main_dat_d;
      main_last_q <= main_last_d;
      skid_dat_q  <= skid_dat_d;
      skid_last_q <= skid_last_d;
      words_q     <= words_d;
    end
  end

endmodule
